enigma_rotor_stepper: RTL and testbench

//  Keypress front end of the Enigma datapath: accepts one plaintext letter per keypress, advances the three rotor positions
//  (including the double-step anomaly), then presents the letter with the post-step positions to the wheel/reflector path.

---
 rtl/enigma_pkg.sv | 29 ++
 rtl/enigma_pos_inc.sv | 19 +
 rtl/enigma_rotor_stepper.sv | 117 +++++++++++
 tb/tb_enigma_rotor_stepper.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma keypress front end: alphabet size,
// letter width, Wehrmacht rotor turnover letters and FSM state encoding.
package enigma_pkg;

    localparam int ALPHA = 26;
    localparam int LW    = 5;

    // Alphabet bounds in letter width, so comparisons stay width-matched.
    localparam logic [LW-1:0] ALPHA_W     = 5'd26;
    localparam logic [LW-1:0] LAST_LETTER = 5'd25;

    // Turnover letters of the five Wehrmacht rotors.
    localparam int TURN_I   = 16;  // Q
    localparam int TURN_II  = 4;   // E
    localparam int TURN_III = 21;  // V
    localparam int TURN_IV  = 9;   // J
    localparam int TURN_V   = 25;  // Z

    // FSM state encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Fold a 5-bit load value into 0..25 (5 bits never exceed 31, so one
    // subtraction of 26 is sufficient).
    function automatic logic [LW-1:0] reduce_letter(input logic [LW-1:0] v);
        return (v >= ALPHA_W) ? (v - ALPHA_W) : v;
    endfunction

endpackage

// File: rtl/enigma_pos_inc.sv
// Combinational mod-26 position increment with enable; 25 wraps to 0 and
// the wrap itself never produces a carry.
module enigma_pos_inc
    import enigma_pkg::*;
(
    input  logic [LW-1:0] pos_in,
    input  logic          en,
    output logic [LW-1:0] pos_out
);

    // Advance one letter when enabled, otherwise pass the position through.
    always_comb begin
        pos_out = pos_in;
        if (en) begin
            pos_out = (pos_in == LAST_LETTER) ? '0 : (pos_in + 5'd1);
        end
    end

endmodule

// File: rtl/enigma_rotor_stepper.sv
// Keypress front end: accepts one letter, steps the three rotors (with the
// middle-rotor double step) and holds letter plus post-step positions for
// the wheel path until it is consumed.
module enigma_rotor_stepper
    import enigma_pkg::*;
#(
    parameter int NOTCH0 = TURN_III,
    parameter int NOTCH1 = TURN_II,
    parameter int NOTCH2 = TURN_I
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [LW-1:0] load_pos0,
    input  logic [LW-1:0] load_pos1,
    input  logic [LW-1:0] load_pos2,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] in_char,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] out_char,
    output logic [LW-1:0] out_pos0,
    output logic [LW-1:0] out_pos1,
    output logic [LW-1:0] out_pos2,
    output logic          out_err
);

    // Turnover letters indexed by rotor (0 = right/fast). The left rotor's
    // notch has nothing further left to drive but is kept for completeness.
    localparam logic [LW-1:0] NOTCH [3] = '{NOTCH0[LW-1:0], NOTCH1[LW-1:0], NOTCH2[LW-1:0]};

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] pos_q   [3];
    logic [LW-1:0] pos_d   [3];
    logic [LW-1:0] pos_inc [3];
    logic [LW-1:0] load_raw[3];
    logic [LW-1:0] load_red[3];
    logic [LW-1:0] char_q, char_d;
    logic          err_q, err_d;
    logic [2:0]    step_en;
    logic          accept;
    logic          char_ok;

    assign load_raw[0] = load_pos0;
    assign load_raw[1] = load_pos1;
    assign load_raw[2] = load_pos2;

    assign in_ready  = (state_q == ST_IDLE) && !load;
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign char_ok   = (in_char < ALPHA_W);

    // Step enables from pre-step positions: the middle rotor also steps
    // when it sits on its own notch, which is the double-step anomaly.
    assign step_en[0] = 1'b1;
    assign step_en[1] = (pos_q[0] == NOTCH[0]) || (pos_q[1] == NOTCH[1]);
    assign step_en[2] = (pos_q[1] == NOTCH[1]);

    // One incrementer and one load reducer per rotor; an out-of-range
    // letter suppresses every step.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rotor
            enigma_pos_inc u_inc (
                .pos_in  (pos_q[gi]),
                .en      (step_en[gi] && char_ok),
                .pos_out (pos_inc[gi])
            );
            assign load_red[gi] = reduce_letter(load_raw[gi]);
        end
    endgenerate

    // Next-state: load overrides everything, then accept, then consume.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        char_d  = char_q;
        err_d   = err_q;
        if (load) begin
            state_d = ST_IDLE;
            pos_d   = load_red;
        end else if (accept) begin
            state_d = ST_HOLD;
            pos_d   = pos_inc;
            char_d  = in_char;
            err_d   = !char_ok;
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    // State registers with synchronous reset, which beats load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            char_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            err_q   <= err_d;
            for (int i = 0; i < 3; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    assign out_char = char_q;
    assign out_err  = err_q;
    assign out_pos0 = pos_q[0];
    assign out_pos1 = pos_q[1];
    assign out_pos2 = pos_q[2];

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Self-checking bench for enigma_rotor_stepper: directed scenarios plus a
// randomized run, all compared against an arithmetic model of rotor stepping.
module tb_enigma_rotor_stepper;

    logic       clk = 1'b0;
    logic       reset, load, in_valid, out_ready;
    logic [4:0] load_pos0, load_pos1, load_pos2, in_char;
    logic       in_ready, out_valid, out_err;
    logic [4:0] out_char, out_pos0, out_pos1, out_pos2;

    int checks = 0;
    int errors = 0;

    // Model state: rotor positions, last accepted letter and error flag.
    int mp0, mp1, mp2, mchar, merr;

    localparam int N0 = 21;
    localparam int N1 = 4;

    always #5 clk = ~clk;

    enigma_rotor_stepper dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_pos0 (load_pos0),
        .load_pos1 (load_pos1),
        .load_pos2 (load_pos2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_pos0  (out_pos0),
        .out_pos1  (out_pos1),
        .out_pos2  (out_pos2),
        .out_err   (out_err)
    );

    // Enigma keypress rule applied to the model.
    function automatic void model_key(input int c);
        bit mid, left;
        mchar = c;
        if (c >= 26) begin
            merr = 1;
            return;
        end
        merr = 0;
        mid  = (mp0 == N0) || (mp1 == N1);
        left = (mp1 == N1);
        mp0  = (mp0 + 1) % 26;
        if (mid)  mp1 = (mp1 + 1) % 26;
        if (left) mp2 = (mp2 + 1) % 26;
    endfunction

    function automatic logic [21:0] model_vec(input bit valid);
        return {valid, merr[0], mchar[4:0], mp2[4:0], mp1[4:0], mp0[4:0]};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {out_valid, out_err, out_char, out_pos2, out_pos1, out_pos0};
    endfunction

    // Present a letter for one cycle from IDLE; returns at the negedge after
    // the accepting edge, where the held output is observable.
    task automatic key(input int c);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = c[4:0];
        @(negedge clk);
        in_valid = 1'b0;
        model_key(c);
    endtask

    task automatic do_load(input int p0, input int p1, input int p2);
        @(negedge clk);
        load      = 1'b1;
        load_pos0 = p0[4:0];
        load_pos1 = p1[4:0];
        load_pos2 = p2[4:0];
        @(negedge clk);
        load = 1'b0;
        mp0  = (p0 >= 26) ? p0 - 26 : p0;
        mp1  = (p1 >= 26) ? p1 - 26 : p1;
        mp2  = (p2 >= 26) ? p2 - 26 : p2;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        load_pos0 = '0; load_pos1 = '0; load_pos2 = '0; in_char = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mp0 = 0; mp1 = 0; mp2 = 0; mchar = 0; merr = 0;
        checks++;
        if ({in_ready, dut_vec()} !== {1'b1, model_vec(1'b0)}) begin
            errors++;
            $display("FAIL reset: got rdy=%b vec=%h want rdy=1 vec=%h", in_ready, dut_vec(), model_vec(1'b0));
        end
    endtask

    task automatic test_single_key();
        do_load(0, 0, 0);
        key(0);
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL single_key: got %h want pos0=1 char=0 valid=1", dut_vec());
        end
        $display("key A -> pos %0d %0d %0d", out_pos2, out_pos1, out_pos0);
    endtask

    task automatic test_double_step();
        logic [14:0] exp_pos [3];
        exp_pos[0] = {5'd0, 5'd3, 5'd21};
        exp_pos[1] = {5'd0, 5'd4, 5'd22};
        exp_pos[2] = {5'd1, 5'd5, 5'd23};
        do_load(20, 3, 0);
        for (int i = 0; i < 3; i++) begin
            key(7);
            checks++;
            if ({out_valid, out_pos2, out_pos1, out_pos0} !== {1'b1, exp_pos[i]}) begin
                errors++;
                $display("FAIL double_step[%0d]: got %0d %0d %0d want %0d %0d %0d", i,
                         out_pos2, out_pos1, out_pos0, exp_pos[i][14:10], exp_pos[i][9:5], exp_pos[i][4:0]);
            end
            $display("double step key %0d -> pos %0d %0d %0d", i, out_pos2, out_pos1, out_pos0);
        end
    endtask

    task automatic test_wrap();
        do_load(25, 0, 0);
        key(2);
        checks++;
        if ({out_pos2, out_pos1, out_pos0} !== 15'd0) begin
            errors++;
            $display("FAIL wrap_25: got %0d %0d %0d want 0 0 0", out_pos2, out_pos1, out_pos0);
        end
        for (int i = 0; i < 26; i++) begin
            key(i);
            checks++;
            if (dut_vec() !== model_vec(1'b1)) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: got %h want %h", i, dut_vec(), model_vec(1'b1));
            end
        end
        checks++;
        if ({out_pos2, out_pos1, out_pos0} !== {5'd0, 5'd1, 5'd0}) begin
            errors++;
            $display("FAIL wrap_turnover: got %0d %0d %0d want 0 1 0", out_pos2, out_pos1, out_pos0);
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] held;
        do_load(10, 2, 6);
        out_ready = 1'b0;
        key(11);
        held = model_vec(1'b1);
        in_valid = 1'b1;
        in_char  = 5'd12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, dut_vec()} !== {1'b0, held}) begin
                errors++;
                $display("FAIL backpressure[%0d]: got rdy=%b vec=%h want rdy=0 vec=%h", i, in_ready, dut_vec(), held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, dut_vec()} !== {1'b1, model_vec(1'b0)}) begin
            errors++;
            $display("FAIL backpressure_release: got rdy=%b vec=%h want rdy=1 vec=%h", in_ready, dut_vec(), model_vec(1'b0));
        end
    endtask

    task automatic test_bad_letter();
        do_load(5, 0, 0);
        key(27);
        checks++;
        if (dut_vec() !== {1'b1, 1'b1, 5'd27, 5'd0, 5'd0, 5'd5}) begin
            errors++;
            $display("FAIL bad_letter: got %h want err=1 char=27 pos 0 0 5", dut_vec());
        end
        key(1);
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 5'd6}) begin
            errors++;
            $display("FAIL bad_letter_clear: got %h want err=0 char=1 pos 0 0 6", dut_vec());
        end
    endtask

    task automatic test_load();
        // load while holding a letter, with a competing keypress
        out_ready = 1'b0;
        key(3);
        @(negedge clk);
        load = 1'b1; load_pos0 = 5'd30; load_pos1 = 5'd2; load_pos2 = 5'd7;
        in_valid = 1'b1; in_char = 5'd9;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: got in_ready=%b want 0", in_ready);
        end
        @(negedge clk);
        load = 1'b0; in_valid = 1'b0;
        mp0 = 4; mp1 = 2; mp2 = 7;
        checks++;
        if ({out_valid, out_pos2, out_pos1, out_pos0} !== {1'b0, 5'd7, 5'd2, 5'd4}) begin
            errors++;
            $display("FAIL load_hold: got v=%b pos %0d %0d %0d want v=0 pos 7 2 4", out_valid, out_pos2, out_pos1, out_pos0);
        end
        out_ready = 1'b1;
        // load together with a keypress while idle
        @(negedge clk);
        load = 1'b1; load_pos0 = 5'd1; load_pos1 = 5'd29; load_pos2 = 5'd25;
        in_valid = 1'b1; in_char = 5'd4;
        @(negedge clk);
        load = 1'b0; in_valid = 1'b0;
        mp0 = 1; mp1 = 3; mp2 = 25;
        @(negedge clk);
        checks++;
        if ({out_valid, out_pos2, out_pos1, out_pos0} !== {1'b0, 5'd25, 5'd3, 5'd1}) begin
            errors++;
            $display("FAIL load_idle: got v=%b pos %0d %0d %0d want v=0 pos 25 3 1", out_valid, out_pos2, out_pos1, out_pos0);
        end
    endtask

    task automatic test_back_to_back();
        do_load(19, 3, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 5'd0;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) model_key(0);
        checks++;
        if (dut_vec() !== model_vec(1'b0)) begin
            errors++;
            $display("FAIL back_to_back: got %h want %h", dut_vec(), model_vec(1'b0));
        end
    endtask

    task automatic test_reset_hold();
        do_load(8, 8, 8);
        out_ready = 1'b0;
        key(5);
        @(negedge clk);
        reset = 1'b1; load = 1'b1;
        load_pos0 = 5'd3; load_pos1 = 5'd3; load_pos2 = 5'd3;
        @(negedge clk);
        reset = 1'b0; load = 1'b0; out_ready = 1'b1;
        mp0 = 0; mp1 = 0; mp2 = 0; mchar = 0; merr = 0;
        checks++;
        if (dut_vec() !== model_vec(1'b0)) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", dut_vec(), model_vec(1'b0));
        end
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
                checks++;
                if ({out_valid, out_pos2, out_pos1, out_pos0} !== {1'b0, mp2[4:0], mp1[4:0], mp0[4:0]}) begin
                    errors++;
                    $display("FAIL random_load[%0d]: got pos %0d %0d %0d want %0d %0d %0d", i,
                             out_pos2, out_pos1, out_pos0, mp2, mp1, mp0);
                end
            end
            c = $urandom_range(0, 29);
            key(c);
            checks++;
            if (dut_vec() !== model_vec(1'b1)) begin
                errors++;
                $display("FAIL random_key[%0d]: got %h want %h", i, dut_vec(), model_vec(1'b1));
            end
            $display("rand %0d key %0d -> pos %0d %0d %0d err %0d", i, c, out_pos2, out_pos1, out_pos0, out_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_double_step();
        test_wrap();
        test_backpressure();
        test_bad_letter();
        test_load();
        test_back_to_back();
        test_reset_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
